// File: rtl/hr_pkg.sv
// rtl/hr_pkg.sv - shared types, widths and helpers for the heart-rate controller
package hr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILTER = 2'd1,
      DETECT = 2'd2
   } state_t;

   localparam int SAMPLE_W       = 10;
   localparam int BPM_W          = 8;
   localparam int PEAK_CNT_W     = 8;
   localparam int TIMEOUT_CYCLES = 255;

   // Clamp a 16-bit product to the 8-bit BPM range.
   function automatic logic [BPM_W-1:0] sat_bpm(input logic [15:0] prod);
      sat_bpm = (prod > 16'd255) ? 8'hFF : prod[BPM_W-1:0];
   endfunction

endpackage

// File: rtl/heart_rate_ctrl_if.sv
// rtl/heart_rate_ctrl_if.sv - sample, FIR handshake and result signals of heart_rate_ctrl
interface heart_rate_ctrl_if;
   import hr_pkg::*;

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;
   logic                filt_start;
   logic [SAMPLE_W-1:0] filt_in;
   logic                filt_done;
   logic [SAMPLE_W-1:0] filt_data;
   logic                peak_pulse;
   logic [BPM_W-1:0]    bpm;
   logic                bpm_valid;
   logic                busy;
   logic                overrun;

   modport slave (
      input  sample_valid, sample, filt_done, filt_data,
      output filt_start, filt_in, peak_pulse, bpm, bpm_valid, busy, overrun
   );

   modport master (
      output sample_valid, sample, filt_done, filt_data,
      input  filt_start, filt_in, peak_pulse, bpm, bpm_valid, busy, overrun
   );

endinterface

// File: rtl/peak_detector.sv
// rtl/peak_detector.sv - three-sample local-maximum detector with refractory hold and peak count
module peak_detector
   import hr_pkg::*;
#(
   parameter int REFRACT_SAMPLES = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_shift,
   input  logic [SAMPLE_W-1:0]   i_data,
   input  logic                  i_detect,
   input  logic                  i_clear,
   output logic                  o_peak,
   output logic [PEAK_CNT_W-1:0] o_count_next
);

   localparam int REF_W = (REFRACT_SAMPLES < 1) ? 1 : $clog2(REFRACT_SAMPLES + 1);

   logic [SAMPLE_W-1:0]   r_h0;
   logic [SAMPLE_W-1:0]   r_h1;
   logic [SAMPLE_W-1:0]   r_h2;
   logic [1:0]            r_fill;
   logic [REF_W-1:0]      r_refract;
   logic [PEAK_CNT_W-1:0] r_count;
   logic                  w_peak;
   logic [PEAK_CNT_W-1:0] w_count_inc;

   // r_h0 is f[n], r_h1 is f[n-1], r_h2 is f[n-2]
   assign w_peak = i_detect && (r_h1 > r_h2) && (r_h1 >= r_h0) &&
                   (r_refract == '0) && (r_fill == 2'd3);

   assign w_count_inc  = (w_peak && (r_count != {PEAK_CNT_W{1'b1}})) ? r_count + 1'b1 : r_count;
   assign o_peak       = w_peak;
   assign o_count_next = w_count_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h0      <= '0;
         r_h1      <= '0;
         r_h2      <= '0;
         r_fill    <= '0;
         r_refract <= '0;
         r_count   <= '0;
      end else begin
         if (i_shift) begin
            r_h2 <= r_h1;
            r_h1 <= r_h0;
            r_h0 <= i_data;
            if (r_fill != 2'd3) begin
               r_fill <= r_fill + 2'd1;
            end
         end
         if (i_detect) begin
            if (w_peak) begin
               r_refract <= REF_W'(REFRACT_SAMPLES);
            end else if (r_refract != '0) begin
               r_refract <= r_refract - 1'b1;
            end
            r_count <= i_clear ? '0 : w_count_inc;
         end
      end
   end

endmodule

// File: rtl/heart_rate_ctrl.sv
// rtl/heart_rate_ctrl.sv - sample/FIR sequencing FSM, BPM window and result; HR_FILTER_TIMEOUT_EN adds a FILTER watchdog
module heart_rate_ctrl
   import hr_pkg::*;
#(
   parameter int WINDOW_SAMPLES  = 1000,
   parameter int REFRACT_SAMPLES = 30,
   parameter int BPM_MULT        = 6
) (
   input  logic              clk,
   input  logic              reset,
   heart_rate_ctrl_if.slave  bus
);

   localparam int WIN_W = $clog2(WINDOW_SAMPLES + 1);

   state_t                r_state;
   state_t                w_next;
   logic                  r_filt_start;
   logic [SAMPLE_W-1:0]   r_filt_in;
   logic                  r_overrun;
   logic [BPM_W-1:0]      r_bpm;
   logic [WIN_W-1:0]      r_win_cnt;

   logic                  w_accept;
   logic                  w_done;
   logic                  w_detect;
   logic                  w_close;
   logic                  w_timeout;
   logic                  w_peak;
   logic [PEAK_CNT_W-1:0] w_count_next;
   logic [15:0]           w_prod;
   logic [BPM_W-1:0]      w_bpm_new;

   assign w_accept = (r_state == IDLE) && bus.sample_valid;
   assign w_done   = (r_state == FILTER) && bus.filt_done;
   assign w_detect = (r_state == DETECT);
   assign w_close  = w_detect && (r_win_cnt == WIN_W'(WINDOW_SAMPLES - 1));

`ifdef HR_FILTER_TIMEOUT_EN
   logic [7:0] r_to_cnt;

   // Abort on the last of TIMEOUT_CYCLES FILTER cycles unless filt_done arrives in it.
   assign w_timeout = (r_state == FILTER) && !bus.filt_done &&
                      (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if (r_state == FILTER) begin
         r_to_cnt <= r_to_cnt + 8'd1;
      end else begin
         r_to_cnt <= '0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.sample_valid) w_next = FILTER;
         FILTER: begin
            if (bus.filt_done) begin
               w_next = DETECT;
            end else if (w_timeout) begin
               w_next = IDLE;
            end
         end
         DETECT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   peak_detector #(
      .REFRACT_SAMPLES (REFRACT_SAMPLES)
   ) u_peak (
      .clk          (clk),
      .reset        (reset),
      .i_shift      (w_done),
      .i_data       (bus.filt_data),
      .i_detect     (w_detect),
      .i_clear      (w_close),
      .o_peak       (w_peak),
      .o_count_next (w_count_next)
   );

   // The count already includes a peak found in the closing DETECT cycle.
   assign w_prod    = 16'(w_count_next) * 16'(BPM_MULT);
   assign w_bpm_new = sat_bpm(w_prod);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_filt_start <= 1'b0;
         r_filt_in    <= '0;
         r_overrun    <= 1'b0;
         r_bpm        <= '0;
         r_win_cnt    <= '0;
      end else begin
         r_filt_start <= w_accept;
         if (w_accept) begin
            r_filt_in <= bus.sample;
         end
         if ((bus.sample_valid && (r_state != IDLE)) || w_timeout) begin
            r_overrun <= 1'b1;
         end
         if (w_detect) begin
            r_win_cnt <= w_close ? '0 : r_win_cnt + 1'b1;
         end
         if (w_close) begin
            r_bpm <= w_bpm_new;
         end
      end
   end

   assign bus.filt_start = r_filt_start;
   assign bus.filt_in    = r_filt_in;
   assign bus.peak_pulse = w_peak;
   assign bus.bpm        = w_close ? w_bpm_new : r_bpm;
   assign bus.bpm_valid  = w_close;
   assign bus.busy       = (r_state != IDLE);
   assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_heart_rate_ctrl.sv
// tb/tb_heart_rate_ctrl.sv - directed self-checking bench for heart_rate_ctrl with a 4-cycle FIR stand-in
module tb_heart_rate_ctrl;
   import hr_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_valid = 1'b0;
   logic [9:0] sample = '0;
   logic       filt_done = 1'b0;
   logic [9:0] filt_data = '0;

   int n_vec  = 0;
   int n_miss = 0;
   int pk_a = 0, bv_a = 0, pk_b = 0, bv_b = 0;
   int pk0, bv0;
   logic       last_fs;
   logic [9:0] last_fin;
   logic       pa, bva, pb, bvb;
   logic [7:0] bpma, bpmb;

   heart_rate_ctrl_if ifa();
   heart_rate_ctrl_if ifb();

   assign ifa.sample_valid = sample_valid;
   assign ifa.sample       = sample;
   assign ifa.filt_done    = filt_done;
   assign ifa.filt_data    = filt_data;
   assign ifb.sample_valid = sample_valid;
   assign ifb.sample       = sample;
   assign ifb.filt_done    = filt_done;
   assign ifb.filt_data    = filt_data;

   heart_rate_ctrl #(.WINDOW_SAMPLES(10), .REFRACT_SAMPLES(2), .BPM_MULT(6))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));

   // Long window, no refractory hold: used to reach 50 peaks in one window.
   heart_rate_ctrl #(.WINDOW_SAMPLES(102), .REFRACT_SAMPLES(0), .BPM_MULT(6))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ifa.peak_pulse === 1'b1) pk_a++;
      if (ifa.bpm_valid === 1'b1)  bv_a++;
      if (ifb.peak_pulse === 1'b1) pk_b++;
      if (ifb.bpm_valid === 1'b1)  bv_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One sample through a FIR that echoes its input 4 cycles after filt_start; returns DETECT-cycle outputs.
   task automatic send(input logic [9:0] v);
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = v;
      @(negedge clk);
      sample_valid = 1'b0;
      last_fs      = ifa.filt_start;
      last_fin     = ifa.filt_in;
      repeat (3) @(negedge clk);
      @(negedge clk);
      filt_done = 1'b1;
      filt_data = v;
      @(negedge clk);
      filt_done = 1'b0;
      pa   = ifa.peak_pulse;
      bva  = ifa.bpm_valid;
      bpma = ifa.bpm;
      pb   = ifb.peak_pulse;
      bvb  = ifb.bpm_valid;
      bpmb = ifb.bpm;
   endtask

   logic [9:0] seq2 [10];
   logic       exp2 [10];

   initial begin
      seq2 = '{10'd1, 10'd5, 10'd3, 10'd4, 10'd9, 10'd2, 10'd2, 10'd2, 10'd2, 10'd2};
      exp2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_busy",       ifa.busy, 0);
      check("rst_filt_start", ifa.filt_start, 0);
      check("rst_peak",       ifa.peak_pulse, 0);
      check("rst_bpm_valid",  ifa.bpm_valid, 0);
      check("rst_bpm",        ifa.bpm, 0);
      check("rst_overrun",    ifa.overrun, 0);
      check("rst_filt_in",    ifa.filt_in, 0);
      @(negedge clk);
      reset = 1'b0;

      // 1,5,3 -> single peak on the third DETECT
      pk0 = pk_a;
      send(10'd1); check("s1_peak_1", pa, 0);
      send(10'd5); check("s1_peak_2", pa, 0);
      check("s1_filt_start", last_fs, 1);
      check("s1_filt_in", last_fin, 5);
      send(10'd3); check("s1_peak_3", pa, 1);
      check("s1_bv_3", bva, 0);
      @(negedge clk);
      check("s1_peak_total", pk_a - pk0, 1);

      // two peaks in a 10-sample window -> bpm 12
      do_reset();
      pk0 = pk_a;
      bv0 = bv_a;
      for (int i = 0; i < 10; i++) begin
         send(seq2[i]);
         check($sformatf("s2_peak_%0d", i + 1), pa, exp2[i]);
         check($sformatf("s2_bv_%0d", i + 1), bva, (i == 9) ? 1 : 0);
      end
      check("s2_bpm_detect", bpma, 12);
      @(negedge clk);
      check("s2_bpm_hold", ifa.bpm, 12);
      check("s2_peak_total", pk_a - pk0, 2);
      check("s2_bv_total", bv_a - bv0, 1);

      // second peak inside refractory period is ignored
      do_reset();
      pk0 = pk_a;
      send(10'd1); send(10'd5); send(10'd3); send(10'd6); send(10'd2);
      check("s3_peak_5", pa, 0);
      @(negedge clk);
      check("s3_peak_total", pk_a - pk0, 1);

      // sample_valid held two cycles, then again in DETECT
      do_reset();
      @(negedge clk);
      sample_valid = 1'b1; sample = 10'd7;
      @(negedge clk);
      sample = 10'd8;
      check("s4_filt_start", ifa.filt_start, 1);
      @(negedge clk);
      sample_valid = 1'b0;
      check("s4_overrun_set", ifa.overrun, 1);
      check("s4_filt_in", ifa.filt_in, 7);
      repeat (2) @(negedge clk);
      @(negedge clk);
      filt_done = 1'b1; filt_data = 10'd7;
      @(negedge clk);
      filt_done = 1'b0;
      sample_valid = 1'b1; sample = 10'd9;
      check("s4_detect_busy", ifa.busy, 1);
      @(negedge clk);
      sample_valid = 1'b0;
      check("s4_idle", ifa.busy, 0);
      check("s4_overrun_sticky", ifa.overrun, 1);
      check("s4_filt_in_kept", ifa.filt_in, 7);
      do_reset();
      check("s4_overrun_clr", ifa.overrun, 0);

      // 50 peaks in a 102-sample window -> saturated bpm
      do_reset();
      pk0 = pk_b;
      bv0 = bv_b;
      for (int i = 0; i < 102; i++) begin
         send((i % 2 == 0) ? 10'd0 : 10'd5);
      end
      check("s5_bv", bvb, 1);
      check("s5_bpm_sat", bpmb, 255);
      @(negedge clk);
      check("s5_peak_total", pk_b - pk0, 50);
      check("s5_bv_total", bv_b - bv0, 1);

      // reset in FILTER, then a stale filt_done
      do_reset();
      pk0 = pk_a;
      @(negedge clk);
      sample_valid = 1'b1; sample = 10'd5;
      @(negedge clk);
      sample_valid = 1'b0;
      check("s6_filt_start", ifa.filt_start, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("s6_rst_busy", ifa.busy, 0);
      check("s6_rst_filt_start", ifa.filt_start, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      filt_done = 1'b1; filt_data = 10'd5;
      @(negedge clk);
      filt_done = 1'b0;
      check("s6_busy", ifa.busy, 0);
      check("s6_filt_start_late", ifa.filt_start, 0);
      check("s6_peak", ifa.peak_pulse, 0);
      @(negedge clk);
      check("s6_peak_total", pk_a - pk0, 0);

      // no filt_done at all
      do_reset();
      @(negedge clk);
      sample_valid = 1'b1; sample = 10'd4;
      @(negedge clk);
      sample_valid = 1'b0;
`ifdef HR_FILTER_TIMEOUT_EN
      repeat (254) @(negedge clk);
      check("to_busy_254", ifa.busy, 1);
      check("to_overrun_254", ifa.overrun, 0);
      @(negedge clk);
      check("to_idle", ifa.busy, 0);
      check("to_overrun", ifa.overrun, 1);
`else
      repeat (300) @(negedge clk);
      check("wait_busy", ifa.busy, 1);
      check("wait_overrun", ifa.overrun, 0);
`endif
      do_reset();
      check("end_idle", ifa.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
